reg_wb_arbiter: RTL and testbench



---
 rtl/mips_pkg.sv | 23 ++
 rtl/wb_fifo.sv | 96 +++++++++
 rtl/reg_wb_arbiter.sv | 106 ++++++++++
 tb/tb_reg_wb_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared constants and the write-back queue entry format used by
//            the register-file write-back arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;
  localparam int REG_ZERO = 0;

  // One queued LSU write-back: destination, payload, and a flag set when a
  // younger ALU write to the same register has made this result stale.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
    logic              kill;
  } wb_entry_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : DEPTH-entry in-order circular buffer of LSU write-backs with an
//            occupancy count and a per-entry kill-match port. Every valid
//            entry whose destination equals match_reg_i is marked killed when
//            match_en_i is high, including an entry pushed in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [AW-1:0]          push_reg_i,
  input  logic [DW-1:0]          push_data_i,
  input  logic                   pop_i,
  input  logic                   match_en_i,
  input  logic [AW-1:0]          match_reg_i,
  output logic [AW-1:0]          head_reg_o,
  output logic [DW-1:0]          head_data_o,
  output logic                   head_kill_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0]    reg_q  [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] kill_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  logic [DEPTH-1:0] hit;
  logic             push_kill;

  // Per-entry WAW match against the ALU destination of this cycle.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign hit[i] = match_en_i && valid_q[i] && (reg_q[i] == match_reg_i);
  end

  // The LSU result being pushed is older than a same-cycle ALU result.
  assign push_kill = match_en_i && (push_reg_i == match_reg_i);

  // Control state: pointers, occupancy, per-entry valid and kill flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      kill_q   <= '0;
    end else begin
      kill_q <= kill_q | hit;
      if (pop_i) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PW'(1);
      end
      if (push_i) begin
        valid_q[wr_ptr_q] <= 1'b1;
        kill_q[wr_ptr_q]  <= push_kill;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage; contents are qualified by valid_q so no reset needed.
  always_ff @(posedge clk) begin
    if (push_i) begin
      reg_q[wr_ptr_q]  <= push_reg_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_reg_o  = reg_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign head_kill_o = kill_q[rd_ptr_q];
  assign count_o     = count_q;
  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CW'(DEPTH));

endmodule : wb_fifo
`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_wb_arbiter
// Purpose  : Register-file write-back arbiter. ALU results win every cycle
//            they are present; LSU results queue in wb_fifo and drain on
//            ALU-idle cycles. Writes to register 0 and stale (killed) LSU
//            results still take their slot but never raise we.
// Revision : 1.0 - initial release
// ============================================================================
module reg_wb_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [AW-1:0]          alu_reg,
  input  logic [DW-1:0]          alu_data,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [AW-1:0]          lsu_reg,
  input  logic [DW-1:0]          lsu_data,
  output logic                   we,
  output logic [AW-1:0]          reg_w,
  output logic [DW-1:0]          bus_w,
  output logic [$clog2(DEPTH):0] fifo_count
);

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [AW-1:0] head_reg;
  logic [DW-1:0] head_data;
  logic          head_kill;
  logic          alu_nonzero;

  logic          we_q,    we_d;
  logic [AW-1:0] reg_w_q, reg_w_d;
  logic [DW-1:0] bus_w_q, bus_w_d;

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign lsu_ready   = !rst && !fifo_full;
  assign fifo_push   = lsu_valid && lsu_ready;
  assign fifo_pop    = !alu_valid && !fifo_empty;
  assign alu_nonzero = (alu_reg != AW'(REG_ZERO));

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_reg_i  (lsu_reg),
    .push_data_i (lsu_data),
    .pop_i       (fifo_pop),
    .match_en_i  (alu_valid && alu_nonzero),
    .match_reg_i (alu_reg),
    .head_reg_o  (head_reg),
    .head_data_o (head_data),
    .head_kill_o (head_kill),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Source selection: ALU first, then FIFO head, otherwise idle and hold.
  always_comb begin
    we_d    = 1'b0;
    reg_w_d = reg_w_q;
    bus_w_d = bus_w_q;
    if (alu_valid) begin
      we_d    = alu_nonzero;
      reg_w_d = alu_reg;
      bus_w_d = alu_data;
    end else if (!fifo_empty) begin
      we_d    = (head_reg != AW'(REG_ZERO)) && !head_kill;
      reg_w_d = head_reg;
      bus_w_d = head_data;
    end
  end

  // Registered write port toward the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      reg_w_q <= '0;
      bus_w_q <= '0;
    end else begin
      we_q    <= we_d;
      reg_w_q <= reg_w_d;
      bus_w_q <= bus_w_d;
    end
  end

  assign we    = we_q;
  assign reg_w = reg_w_q;
  assign bus_w = bus_w_q;

endmodule : reg_wb_arbiter
`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_wb_arbiter
// Purpose  : Directed self-checking bench for reg_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_reg;
  logic [31:0] lsu_data;
  logic        we;
  logic [4:0]  reg_w;
  logic [31:0] bus_w;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  reg_wb_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_reg    (alu_reg),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_reg    (lsu_reg),
    .lsu_data   (lsu_data),
    .we         (we),
    .reg_w      (reg_w),
    .bus_w      (bus_w),
    .fifo_count (fifo_count)
  );

  // Consumer-side register file fed by the write port.
  always @(negedge clk) begin
    if (we) rf[reg_w] <= bus_w;
  end

  // Occupancy must stay within 0..DEPTH at all times.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      total++;
      assert (fifo_count <= 3'd4) else begin
        bad++;
        $error("FAIL count_range observed=%0d expected<=4", fifo_count);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst = 1'b1; alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    lsu_valid = 1'b1; lsu_reg = 5'd1; lsu_data = 32'hDEAD;

    // Reset held two cycles with an LSU offer pending.
    tick(); tick();
    chk("rst_ready", {31'd0, lsu_ready}, 32'd0);
    chk("rst_we",    {31'd0, we}, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_regw",  {27'd0, reg_w}, 32'd0);
    chk("rst_busw",  bus_w, 32'd0);
    rst = 1'b0; lsu_valid = 1'b0;
    tick();
    chk("post_rst_ready", {31'd0, lsu_ready}, 32'd1);
    chk("post_rst_count", {29'd0, fifo_count}, 32'd0);

    // ALU-only write, then an idle cycle holding reg_w/bus_w.
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h12345678;
    tick();
    chk("alu_we",   {31'd0, we}, 32'd1);
    chk("alu_regw", {27'd0, reg_w}, 32'd3);
    chk("alu_busw", bus_w, 32'h12345678);
    alu_valid = 1'b0;
    tick();
    chk("idle_we",   {31'd0, we}, 32'd0);
    chk("idle_regw", {27'd0, reg_w}, 32'd3);
    chk("idle_busw", bus_w, 32'h12345678);

    // Fill the FIFO under continuous ALU traffic.
    alu_valid = 1'b1; alu_reg = 5'd20; alu_data = 32'h20;
    lsu_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      lsu_reg = 5'(4 + k); lsu_data = 32'hA0 + 32'(k);
      tick();
    end
    chk("full_count", {29'd0, fifo_count}, 32'd4);
    chk("full_ready", {31'd0, lsu_ready}, 32'd0);
    chk("full_alu_we", {31'd0, we}, 32'd1);
    chk("full_alu_reg", {27'd0, reg_w}, 32'd20);
    lsu_reg = 5'd30; lsu_data = 32'hBAD;
    tick();
    chk("full_no_push", {29'd0, fifo_count}, 32'd4);

    // Drain in order once the ALU goes idle.
    alu_valid = 1'b0; lsu_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain_we",    {31'd0, we}, 32'd1);
      chk("drain_reg",   {27'd0, reg_w}, 32'(4 + k));
      chk("drain_data",  bus_w, 32'hA0 + 32'(k));
      chk("drain_count", {29'd0, fifo_count}, 32'(3 - k));
    end
    tick();
    chk("drained_we", {31'd0, we}, 32'd0);
    chk("drained_ready", {31'd0, lsu_ready}, 32'd1);

    // WAW: queued LSU r9 is superseded by a later ALU r9.
    lsu_valid = 1'b1; lsu_reg = 5'd9; lsu_data = 32'h1;
    tick();
    chk("waw_count", {29'd0, fifo_count}, 32'd1);
    lsu_valid = 1'b0;
    alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'h2;
    tick();
    chk("waw_alu_we",   {31'd0, we}, 32'd1);
    chk("waw_alu_data", bus_w, 32'h2);
    alu_valid = 1'b0;
    tick();
    chk("waw_kill_we",   {31'd0, we}, 32'd0);
    chk("waw_kill_reg",  {27'd0, reg_w}, 32'd9);
    chk("waw_kill_data", bus_w, 32'h1);
    chk("waw_kill_cnt",  {29'd0, fifo_count}, 32'd0);
    tick();
    chk("waw_rf9", rf[9], 32'h2);

    // Same-cycle push and ALU write to the same register.
    lsu_valid = 1'b1; lsu_reg = 5'd11; lsu_data = 32'h5;
    alu_valid = 1'b1; alu_reg = 5'd11; alu_data = 32'h6;
    tick();
    chk("same_alu_data", bus_w, 32'h6);
    chk("same_count", {29'd0, fifo_count}, 32'd1);
    lsu_valid = 1'b0; alu_valid = 1'b0;
    tick();
    chk("same_kill_we", {31'd0, we}, 32'd0);
    tick();
    chk("same_rf11", rf[11], 32'h6);

    // Register 0 from both sources.
    lsu_valid = 1'b1; lsu_reg = 5'd0; lsu_data = 32'h66;
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'h55;
    tick();
    chk("r0_alu_we",   {31'd0, we}, 32'd0);
    chk("r0_alu_data", bus_w, 32'h55);
    chk("r0_count",    {29'd0, fifo_count}, 32'd1);
    lsu_valid = 1'b0; alu_valid = 1'b0;
    tick();
    chk("r0_lsu_we",    {31'd0, we}, 32'd0);
    chk("r0_lsu_data",  bus_w, 32'h66);
    chk("r0_drained",   {29'd0, fifo_count}, 32'd0);

    // Mid-operation reset with three queued entries.
    alu_valid = 1'b1; alu_reg = 5'd21; alu_data = 32'h21;
    lsu_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lsu_reg = 5'(12 + k); lsu_data = 32'hC0 + 32'(k);
      tick();
    end
    chk("mid_count", {29'd0, fifo_count}, 32'd3);
    alu_valid = 1'b0; lsu_valid = 1'b0; rst = 1'b1;
    tick();
    chk("mid_rst_count", {29'd0, fifo_count}, 32'd0);
    chk("mid_rst_we",    {31'd0, we}, 32'd0);
    chk("mid_rst_busw",  bus_w, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_after_we", {31'd0, we}, 32'd0);
    end
    chk("mid_rf12", rf[12], 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_wb_arbiter
`default_nettype wire
